fnd_scan_controller: RTL

//  Parametrised N-digit common-anode 7-segment scan controller: next generation of the 4-digit FND driver.

---
 rtl/fnd_pkg.sv | 36 +++
 rtl/fnd_scan_controller_if.sv | 12 +
 rtl/fnd_scan_controller_bin2bcd_seq.sv | 79 +++++++
 rtl/fnd_scan_controller.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared segment codes, converter state encoding and divider helper
// for the FND scan controller and its BCD converter.
package fnd_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   typedef enum logic [1:0] {
      CONV_IDLE  = 2'd0,
      CONV_SHIFT = 2'd1,
      CONV_DONE  = 2'd2
   } conv_state_t;

   // Active-low {dp,g,f,e,d,c,b,a}; dp stays dark here and is merged by the scan mux.
   function automatic logic [7:0] seg_of(input logic [3:0] bcd);
      case (bcd)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return SEG_BLANK;
      endcase
   endfunction

   function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned hz);
      if (hz == 0 || clk_hz < hz) return 1;
      return clk_hz / hz;
   endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// fnd_scan_controller_if: load/value/busy handshake between a datapath (master)
// and the FND scan controller (slave).
interface fnd_scan_controller_if #(
   parameter int DATA_W = 14
);
   logic              load;
   logic [DATA_W-1:0] value;
   logic              busy;

   modport master (output load, output value, input busy);
   modport slave  (input load, input value, output busy);
endinterface

// File: rtl/fnd_scan_controller_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one input bit per cycle, flagging
// values that need more than NUM_DIGITS decimal digits.
module bin2bcd_seq
   import fnd_pkg::*;
#(
   parameter int DATA_W     = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [DATA_W-1:0]       value,
   output logic                    busy,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    ovf_out,
   output logic                    done
);
   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);

   conv_state_t       state;
   logic [DATA_W-1:0] bin_q;
   logic [CNT_W-1:0]  cnt;
   logic [BCD_W-1:0]  bcd_adj;
   logic              start;

   // A start is accepted in IDLE and in DONE, so back-to-back conversions keep busy high.
   assign start = load && (state == CONV_IDLE || state == CONV_DONE);

   // NOTE: every combinational output gets a default before any conditional update, so no latch is inferred.
   always_comb begin
      bcd_adj = bcd_out;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (bcd_out[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_out[4*d +: 4] + 4'd3;
      end
   end

   // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= CONV_IDLE;
         bin_q   <= '0;
         cnt     <= '0;
         bcd_out <= '0;
         ovf_out <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (start) begin
         state   <= CONV_SHIFT;
         bin_q   <= value;
         cnt     <= '0;
         bcd_out <= '0;
         ovf_out <= 1'b0;
         busy    <= 1'b1;
         done    <= 1'b0;
      end else begin
         case (state)
            CONV_SHIFT: begin
               // Any bit leaving the top digit means the value needs an extra decimal digit.
               bcd_out <= {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
               ovf_out <= ovf_out | bcd_adj[BCD_W-1];
               bin_q   <= bin_q << 1;
               cnt     <= cnt + 1'b1;
               if (cnt == CNT_W'(DATA_W - 1)) begin
                  state <= CONV_DONE;
                  done  <= 1'b1;
               end
            end
            CONV_DONE: begin
               state <= CONV_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: state <= CONV_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: N-digit common-anode 7-segment scanner with sequential BCD conversion,
// leading-zero blanking, dots and blink. Define FND_PWM_EN for per-digit brightness PWM.
module fnd_scan_controller
   import fnd_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DATA_W     = 14,
   parameter int CLK_HZ     = 100_000_000,
   parameter int SCAN_HZ    = 1_000,
   parameter int BLINK_HZ   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   fnd_scan_controller_if.slave  bus,
   input  logic [NUM_DIGITS-1:0] dot_sel,
   input  logic                  blink_en,
   input  logic                  lz_blank,
   input  logic [2:0]            bright,
   output logic [NUM_DIGITS-1:0] fndCom,
   output logic [7:0]            fndFont
);
   localparam int SCAN_DIV  = int'(tick_div(CLK_HZ, SCAN_HZ));
   localparam int BLINK_DIV = int'(tick_div(CLK_HZ, 2 * BLINK_HZ));
   localparam int SCAN_W    = $clog2(SCAN_DIV + 1);
   localparam int BLINK_W   = $clog2(BLINK_DIV + 1);
   localparam int IDX_W     = $clog2(NUM_DIGITS);
   localparam int BCD_W     = 4 * NUM_DIGITS;

   logic                  conv_start;
   logic [DATA_W-1:0]     conv_value;
   logic                  conv_busy;
   logic                  conv_done;
   logic                  conv_ovf;
   logic [BCD_W-1:0]      conv_bcd;

   logic                  pend_valid;
   logic [DATA_W-1:0]     pend_value;

   logic [NUM_DIGITS-1:0][3:0] disp_bcd;
   logic                  disp_ovf;

   logic [SCAN_W-1:0]     scan_cnt;
   logic [IDX_W-1:0]      scan_idx;
   logic [BLINK_W-1:0]    blink_cnt;
   logic                  blink_on;
   logic                  scan_tick;
   logic                  blink_tick;
   logic                  pwm_on;

   logic                  zero_above;
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  digit_off;
   logic [NUM_DIGITS-1:0] com_next;
   logic [7:0]            font_next;

   // A load in DONE starts the next conversion directly; the newest value always wins.
   assign conv_start = (bus.load && !conv_busy) || (conv_done && (pend_valid || bus.load));
   assign conv_value = bus.load ? bus.value : pend_value;
   assign bus.busy   = conv_busy;

   bin2bcd_seq #(
      .DATA_W     (DATA_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bin2bcd (
      .clk     (clk),
      .reset   (reset),
      .load    (conv_start),
      .value   (conv_value),
      .busy    (conv_busy),
      .bcd_out (conv_bcd),
      .ovf_out (conv_ovf),
      .done    (conv_done)
   );

   // NOTE: the display register is reset like any other state, since a cleared display after reset is visible behaviour.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_valid <= 1'b0;
         pend_value <= '0;
         disp_bcd   <= '0;
         disp_ovf   <= 1'b0;
      end else begin
         if (conv_start) begin
            pend_valid <= 1'b0;
         end else if (bus.load) begin
            pend_valid <= 1'b1;
            pend_value <= bus.value;
         end
         if (conv_done) begin
            disp_bcd <= conv_bcd;
            disp_ovf <= conv_ovf;
         end
      end
   end

   assign scan_tick  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign blink_tick = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt  <= '0;
         scan_idx  <= '0;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else begin
         if (scan_tick) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         if (blink_tick) begin
            blink_cnt <= '0;
            blink_on  <= !blink_on;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

`ifdef FND_PWM_EN
   // Slot split into eighths: enabled while position*8 < (bright+1)*slot length.
   assign pwm_on = (32'({scan_cnt, 3'b000}) < ((32'(bright) + 32'd1) * 32'(SCAN_DIV)));
`else
   logic unused_bright;
   assign unused_bright = ^bright;
   assign pwm_on        = 1'b1;
`endif

   always_comb begin
      zero_above = 1'b1;
      lz_mask    = '0;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         zero_above = zero_above && (disp_bcd[k] == 4'd0);
         lz_mask[k] = zero_above;
      end

      font_next = disp_ovf ? SEG_DASH : seg_of(disp_bcd[scan_idx]);
      if (dot_sel[scan_idx] && blink_on) font_next[7] = 1'b0;

      digit_off = (lz_blank && !disp_ovf && lz_mask[scan_idx]) ||
                  (blink_en && !blink_on) || !pwm_on;

      com_next = '1;
      if (digit_off) font_next = SEG_BLANK;
      else           com_next[scan_idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fndCom  <= '1;
         fndFont <= SEG_BLANK;
      end else begin
         fndCom  <= com_next;
         fndFont <= font_next;
      end
   end

endmodule
